// File: rtl/act_gate.sv
// act_gate: ACT admission gate combining bloom-filter verdicts with a blacklist history.
// Optional per-core perf throttling is enabled by defining ACT_GATE_PERF_THROTTLE_EN.
module act_gate #(
  parameter int ROW_W    = 16,
  parameter int CORE_W   = 3,
  parameter int HB_DEPTH = 16,
  parameter int T_DELAY  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ROW_W-1:0]     req_row,
  input  logic [CORE_W-1:0]    req_core,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [ROW_W-1:0]     issue_row,
  output logic [CORE_W-1:0]    issue_core,
  output logic [ROW_W-1:0]     bf_row_addr,
  output logic [CORE_W-1:0]    bf_core_id,
  output logic                 bf_insert_valid,
  input  logic                 bf_aggressor,
  input  logic                 bf_perf_attack,
  output logic [15:0]          blocked_cnt,
  output logic [2**CORE_W-1:0] perf_flags,
  input  logic                 perf_clr
);

  localparam int TS_W = $clog2(T_DELAY) + 1;
  localparam int PW   = $clog2(HB_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [TS_W-1:0] TD   = TS_W'(T_DELAY);
  localparam logic [CW-1:0]   FULL = CW'(HB_DEPTH);

  typedef enum logic [2:0] {
    IDLE, QUERY, CHECK, STALL, ISSUE
  } state_t;

  state_t state, state_nx;

  logic [ROW_W-1:0]  p_row;
  logic [CORE_W-1:0] p_core;
  logic              agg;
  logic              ready_q;
  logic [TS_W-1:0]   ts_now;

  logic              hb_v   [HB_DEPTH];
  logic [ROW_W-1:0]  hb_row [HB_DEPTH];
  logic [TS_W-1:0]   hb_ts  [HB_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt;

  logic hit, head_live, hb_full, hb_stall, thr;
  logic push, pop, req_fire, iss_fire;

  assign req_ready       = ready_q;
  assign req_fire        = req_valid && ready_q;
  assign iss_fire        = (state == ISSUE) && issue_ready;
  assign issue_valid     = (state == ISSUE);
  assign bf_insert_valid = iss_fire;
  assign issue_row       = p_row;
  assign issue_core      = p_core;
  assign bf_row_addr     = p_row;
  assign bf_core_id      = p_core;

  // Ages are modular in TS_W bits; entries never outlive T_DELAY+1 cycles
  assign head_live = hb_v[head] && ((ts_now - hb_ts[head]) < TD);
  assign pop       = hb_v[head] && !head_live;
  assign hb_full   = (cnt == FULL);
  assign hb_stall  = agg && (hit || (hb_full && head_live));
  assign push      = iss_fire && agg && (!hb_full || pop);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HB_DEPTH; i++) begin
      if (hb_v[i] && (hb_row[i] == p_row) &&
          ((ts_now - hb_ts[i]) < TD))
        hit = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_fire) state_nx = QUERY;
      QUERY:   state_nx = CHECK;
      CHECK:   state_nx = (hb_stall || thr) ? STALL : ISSUE;
      STALL:   state_nx = hb_stall ? STALL : ISSUE;
      ISSUE:   if (issue_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      p_row   <= '0;
      p_core  <= '0;
      agg     <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == IDLE);
      if (req_fire) begin
        p_row  <= req_row;
        p_core <= req_core;
      end
      if (state == QUERY) agg <= bf_aggressor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_cnt <= '0;
    end else if ((state == STALL) && (blocked_cnt != 16'hFFFF)) begin
      blocked_cnt <= blocked_cnt + 16'd1;
    end
  end

  // Pop clears before push sets, so a push may reuse the slot freed this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_now <= '0;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      for (int i = 0; i < HB_DEPTH; i++) begin
        hb_v[i]   <= 1'b0;
        hb_row[i] <= '0;
        hb_ts[i]  <= '0;
      end
    end else begin
      ts_now <= ts_now + TS_W'(1);
      if (pop) begin
        hb_v[head] <= 1'b0;
        head       <= head + PW'(1);
      end
      if (push) begin
        hb_v[tail]   <= 1'b1;
        hb_row[tail] <= p_row;
        hb_ts[tail]  <= ts_now;
        tail         <= tail + PW'(1);
      end
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
    end
  end

`ifdef ACT_GATE_PERF_THROTTLE_EN
  assign thr = perf_flags[p_core];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flags <= '0;
    end else begin
      if (perf_clr) perf_flags <= '0;
      if ((state == QUERY) && bf_perf_attack)
        perf_flags[p_core] <= 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{perf_clr, bf_perf_attack};
  assign thr         = 1'b0;
  assign perf_flags  = '0;
`endif

endmodule

// File: tb/tb_act_gate.sv
// tb_act_gate: directed stimulus for act_gate with a transaction-level
// model of the history buffer checked on every cycle.
module tb_act_gate;

  localparam int T_DELAY  = 1024;
  localparam int HB_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_row = '0;
  logic [2:0]  req_core = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b1;
  logic [15:0] issue_row;
  logic [2:0]  issue_core;
  logic [15:0] bf_row_addr;
  logic [2:0]  bf_core_id;
  logic        bf_insert_valid;
  logic        bf_aggressor = 1'b0;
  logic        bf_perf_attack = 1'b0;
  logic [15:0] blocked_cnt;
  logic [7:0]  perf_flags;
  logic        perf_clr = 1'b0;

  act_gate dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_core(req_core),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_row(issue_row), .issue_core(issue_core),
    .bf_row_addr(bf_row_addr), .bf_core_id(bf_core_id),
    .bf_insert_valid(bf_insert_valid),
    .bf_aggressor(bf_aggressor), .bf_perf_attack(bf_perf_attack),
    .blocked_cnt(blocked_cnt), .perf_flags(perf_flags),
    .perf_clr(perf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ins_cnt = 0;
  bit seen;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) seen <= 1'b0;
    else seen <= 1'b1;

  always @(negedge clk) if (bf_insert_valid) ins_cnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: issued aggressor ACTs as (row, issue cycle)
  int          h_cyc[$];
  logic [15:0] h_row[$];

  function automatic bit model_stall(int y, logic [15:0] row);
    int live = 0;
    bit m = 0;
    foreach (h_cyc[i]) begin
      if (y - h_cyc[i] < T_DELAY) begin
        live++;
        if (h_row[i] == row) m = 1;
      end
    end
    return m || (live >= HB_DEPTH);
  endfunction

  bit          m_busy = 0, m_rdone = 0, m_agg = 0;
  int          m_acc, m_k, m_R, m_rise, m_blk = 0;
  logic [15:0] m_row;
  logic [2:0]  m_core;
  logic [7:0]  m_flags = '0;

  always @(negedge clk) begin
    int eb;
    bit ev;
    logic [7:0] nf;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_insert", bf_insert_valid, 0);
      chk("rst_blocked", blocked_cnt, 0);
      chk("rst_perf", perf_flags, 0);
      m_busy = 0; m_rdone = 0; m_blk = 0; m_flags = '0;
      h_cyc.delete(); h_row.delete();
    end else begin
      if (m_busy && !m_rdone && cyc == m_k) begin
        m_R = m_k;
        while (m_agg && model_stall(m_R, m_row) && m_R < m_k + 5000)
          m_R++;
`ifdef ACT_GATE_PERF_THROTTLE_EN
        if (m_flags[m_core] && m_R < m_k + 1) m_R = m_k + 1;
`endif
        m_rise = m_R + 1;
        m_rdone = 1;
      end
      ev = m_busy && m_rdone && (cyc >= m_rise);
      eb = m_blk;
      if (m_busy && m_rdone && (cyc - 1 >= m_k + 1))
        eb += ((cyc - 1 < m_R) ? cyc - 1 : m_R) - m_k;
      chk("req_ready", req_ready, seen && !m_busy);
      chk("issue_valid", issue_valid, ev);
      chk("insert", bf_insert_valid, ev && issue_ready);
      chk("blocked_cnt", blocked_cnt, eb);
      chk("perf_flags", perf_flags, m_flags);
      if (m_busy && cyc > m_acc) begin
        chk("issue_row", issue_row, m_row);
        chk("issue_core", issue_core, m_core);
        chk("bf_row_addr", bf_row_addr, m_row);
      end
      nf = m_flags;
`ifdef ACT_GATE_PERF_THROTTLE_EN
      if (perf_clr) nf = '0;
      if (m_busy && cyc == m_acc + 1 && bf_perf_attack) nf[m_core] = 1'b1;
`endif
      m_flags = nf;
      if (ev && issue_ready) begin
        m_blk += m_R - m_k;
        if (m_agg) begin
          h_cyc.push_back(cyc);
          h_row.push_back(m_row);
        end
        m_busy = 0;
      end else if (!m_busy && seen && req_valid) begin
        m_busy = 1; m_rdone = 0;
        m_acc = cyc; m_k = cyc + 2;
        m_row = req_row; m_core = req_core; m_agg = bf_aggressor;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [15:0] row, input logic [2:0] core,
                        input logic agg, input logic pa, input int hold,
                        input int budget, output int acc, output int rise);
    int n = 0;
    rise = -1;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_row = row; req_core = core; req_valid = 1'b1;
    bf_aggressor = agg; bf_perf_attack = pa;
    issue_ready = (hold == 0);
    acc = cyc;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!issue_valid && n < budget) begin tick(); n++; end
    if (!issue_valid) begin
      chk("issue_timeout", 0, 1);
      issue_ready = 1'b1;
      return;
    end
    rise = cyc;
    repeat (hold) tick();
    issue_ready = 1'b1;
    tick();
  endtask

  initial begin
    int a, r, t0, blk0, ins0;
    // Reset
    repeat (3) tick();
    chk("init_req_ready", req_ready, 0);
    chk("init_issue_valid", issue_valid, 0);
    chk("init_blocked", blocked_cnt, 0);
    rst_n = 1'b1;
    chk("ready_before_edge", req_ready, 0);
    tick();
    chk("ready_after_edge", req_ready, 1);

    // Unblocked non-aggressor
    ins0 = ins_cnt;
    do_req(16'h1234, 3'd1, 1'b0, 1'b0, 0, 50, a, r);
    chk("t1_latency", r - a, 3);
    chk("t1_insert_pulses", ins_cnt - ins0, 1);
    chk("t1_blocked", blocked_cnt, 0);

    // Blacklisted row re-request
    do_req(16'h00AA, 3'd2, 1'b1, 1'b0, 0, 50, a, t0);
    chk("t2_first_latency", t0 - a, 3);
    blk0 = blocked_cnt;
    do_req(16'h00AA, 3'd2, 1'b1, 1'b0, 0, 2000, a, r);
    chk("t2_release", r, t0 + T_DELAY + 1);
    chk("t2_blocked", blocked_cnt - blk0, r - (a + 3));

    // Backpressure on issue
    ins0 = ins_cnt;
    do_req(16'h0777, 3'd3, 1'b0, 1'b0, 10, 50, a, r);
    chk("t4_latency", r - a, 3);
    chk("t4_insert_pulses", ins_cnt - ins0, 1);

    repeat (1100) tick();

    // Fill the history buffer, then a 17th aggressor
    for (int i = 0; i < 16; i++) begin
      do_req(16'h0100 + 16'(i), 3'(i), 1'b1, 1'b0, 0, 50, a, r);
      if (i == 0) t0 = r;
    end
    do_req(16'h0200, 3'd4, 1'b1, 1'b0, 0, 2000, a, r);
    chk("t3_full_release", r, t0 + T_DELAY + 1);
    do_req(16'h0300, 3'd6, 1'b0, 1'b0, 0, 50, a, r);
    chk("t3_nonagg_latency", r - a, 3);

    // Reset during a stall
    blk0 = blocked_cnt;
    req_row = 16'h0200; req_core = 3'd4; bf_aggressor = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (20) tick();
    chk("t5_stalled", issue_valid, 0);
    chk("t5_counting", blocked_cnt > blk0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_valid", issue_valid, 0);
    chk("t5_rst_insert", bf_insert_valid, 0);
    chk("t5_rst_blocked", blocked_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_req(16'h0200, 3'd4, 1'b1, 1'b0, 0, 50, a, r);
    chk("t5_after_rst_latency", r - a, 3);

`ifdef ACT_GATE_PERF_THROTTLE_EN
    do_req(16'h0500, 3'd5, 1'b0, 1'b1, 0, 50, a, r);
    chk("t6_flags", perf_flags, 8'h20);
    do_req(16'h0501, 3'd5, 1'b0, 1'b0, 0, 50, a, r);
    chk("t6_throttle_latency", r - a, 4);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("t6_clr", perf_flags, 0);
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/act_gate.md
# act_gate

Activation gate sitting between the per-bank request queue and the DRAM command issuer; it is the consumer-side partner of the counting bloom filter pair. For every ACT request it presents the row and core to the filter, reads back the aggressor/perf-attack verdict, and checks a history buffer of recently issued blacklisted activations. A blacklisted row activated less than `T_DELAY` cycles ago is held; otherwise the ACT is forwarded, and the filter is told to insert it.

## Interface
- `ROW_W`, 16: row address width.
- `CORE_W`, 3: core id width.
- `HB_DEPTH`, 16: history buffer entries (power of two).
- `T_DELAY`, 1024: minimum cycles between two issued ACTs to the same blacklisted row.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: ACT request handshake.
- `req_row` in `ROW_W`, `req_core` in `CORE_W`: request payload.
- `issue_valid` out 1, `issue_ready` in 1: forwarded ACT handshake.
- `issue_row` out `ROW_W`, `issue_core` out `CORE_W`: forwarded payload.
- `bf_row_addr` out `ROW_W`, `bf_core_id` out `CORE_W`: filter query/insert address.
- `bf_insert_valid` out 1: one-cycle insert pulse.
- `bf_aggressor` in 1, `bf_perf_attack` in 1: combinational filter verdict for `bf_row_addr`/`bf_core_id`.
- `blocked_cnt` out 16: saturating count of stall cycles.
- `perf_flags` out `2**CORE_W`: sticky per-core perf-attack flags.
- `perf_clr` in 1: clears `perf_flags`.

## Operation
- FSM: IDLE -> QUERY -> CHECK -> (STALL) -> ISSUE -> IDLE.
- IDLE: `req_ready`=1. On `req_valid&&req_ready`, capture row/core into a payload register and go to QUERY.
- `bf_row_addr`/`bf_core_id`/`issue_row`/`issue_core` are driven from the payload register at all times.
- QUERY: register `bf_aggressor` as `agg` (and `bf_perf_attack`). Go to CHECK.
- CHECK: CAM-search the valid HB entries for a row match.
  - Stall when `agg` is set and either condition holds: a matching entry has age < `T_DELAY`, or the HB is full and its head has not expired.
  - A stalled request goes to STALL; otherwise it goes to ISSUE.
- STALL: re-evaluate the CHECK condition every cycle and go to ISSUE in the first cycle it is false. `blocked_cnt` increments each STALL cycle and saturates at 16'hFFFF.
- ISSUE: `issue_valid`=1 until `issue_ready`. On the handshake cycle:
  - `bf_insert_valid`=1 for exactly that cycle.
  - If `agg`, push {row, timestamp} at the HB tail.
  - Go to IDLE.
- History buffer:
  - Circular FIFO of {valid, row, ts}.
  - `ts_now` is a free-running counter of width clog2(`T_DELAY`)+1. It wraps modulo 2^width.
  - age = `ts_now` - ts, computed modulo that width.
  - Each cycle, if the head is valid with age >= `T_DELAY`, pop it.
  - A push and a pop in the same cycle are both performed. The count is unchanged, and a push into a slot freed that cycle is legal.
  - Because expired heads are popped every cycle, no entry lives past `T_DELAY`+1 cycles, so the modular age is never ambiguous.
- Duplicate rows may coexist in the HB. A stall lasts until every matching entry has expired.
- A non-aggressor request never consults the HB outcome and never pushes.

## Timing
- Reset values:
  - `req_ready`=0, `issue_valid`=0, `bf_insert_valid`=0.
  - `blocked_cnt`=0, `perf_flags`=0.
  - payload=0, HB empty, `ts_now`=0, state IDLE.
- `req_ready` rises in the first `clk` edge after `rst_n` deasserts.
- Unblocked latency: accept at cycle 0, QUERY cycle 1, CHECK cycle 2, `issue_valid` high from cycle 3.
- Blocked request: `issue_valid` rises in the cycle after the last matching entry's age reaches `T_DELAY`.
- `issue_valid` and payload are stable while waiting for `issue_ready`. There is no retraction.
- `req_ready` is 0 in every state except IDLE. One request is in flight at a time.
- Reset mid-operation: `rst_n` low immediately drops all outputs to their reset values and empties the HB. An in-flight request is discarded and nothing is inserted.

## Configuration
- `ACT_GATE_PERF_THROTTLE_EN` defined:
  - On entering CHECK with registered `bf_perf_attack`=1, set `perf_flags[core]`.
  - `perf_clr` clears all flags. If a set and `perf_clr` occur in the same cycle, the set wins.
  - An ACT whose `perf_flags[core]` is set spends one extra STALL cycle before ISSUE.
- Not defined:
  - `bf_perf_attack` is ignored and `perf_clr` is unused.
  - `perf_flags` is constant 0 and no extra stall is added.

## Test plan
- Reset, single request row 0x1234, `bf_aggressor`=0, `issue_ready`=1 -> `issue_valid` at cycle 3 with row 0x1234, one `bf_insert_valid` pulse, HB stays empty, `blocked_cnt`=0.
- Row 0x00AA, `bf_aggressor`=1, issued at `ts_now`=t -> re-request of 0x00AA stalls. `issue_valid` rises at t+`T_DELAY`+1, and `blocked_cnt` equals the stall cycles.
- Fill the HB with 16 distinct aggressor rows within 100 cycles, then send a 17th aggressor row -> it stalls until the head expires, then issues. A non-aggressor request issues in 3 cycles despite the full HB.
- Hold `issue_ready`=0 for 10 cycles -> `issue_valid`/payload stable, `req_ready`=0, and `bf_insert_valid` pulses only on the handshake cycle.
- Assert `rst_n`=0 during STALL -> outputs at their reset values immediately. After release, a re-request of the same row issues unblocked in 3 cycles.
- With `ACT_GATE_PERF_THROTTLE_EN` defined: `bf_perf_attack`=1 for core 5 -> `perf_flags`=8'h20 and the next core-5 ACT takes 4 cycles. `perf_clr` returns `perf_flags` to 0.
